// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Shared constants and types for the five-stage MIPS pipeline.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        BP_WAIT = 1'b1
    } bp_state_t;

endpackage

`default_nettype wire

// File: rtl/pc_reg.sv
// ============================================================================
// Module : pc_reg
// Program counter with async reset, load enable and redirect mux.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pc_reg #(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);
    import cpu_pkg::*;

    logic [31:0] pc_next;

    assign pc_plus4 = pc + PC_INC;

    // Redirect overrides a hold; the caller folds hold into load_en.
    always_comb begin
        pc_next = pc;
        if (redirect)
            pc_next = redirect_target;
        else if (load_en)
            pc_next = pc_plus4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= RESET_PC;
        else
            pc <= pc_next;
    end

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module : if_stage
// Instruction fetch: PC, IF/ID register, breakpoint FSM and fetch counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module if_stage #(
    parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        stall_breakpoint,
    input  logic        continue_en,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc_next,
    output logic        flush_id,
    output logic        bp_halted,
    output logic [31:0] fetch_count
);
    import cpu_pkg::*;

    logic        hold;
    logic        advance;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    bp_state_t   state;
    bp_state_t   state_next;

    assign hold      = stall | (stall_breakpoint & ~continue_en);
    assign advance   = ~redirect & ~hold;
    assign imem_addr = pc;
    assign flush_id  = redirect;
    assign bp_halted = (state == BP_WAIT);

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk             (clk),
        .rst_n           (rst_n),
        .load_en         (~hold),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .pc              (pc),
        .pc_plus4        (pc_plus4)
    );

    // IF/ID register: bubble on redirect, freeze on hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_instruction <= NOP_INSTR;
            if_id_pc_next     <= 32'd0;
        end else if (redirect) begin
            if_id_instruction <= NOP_INSTR;
            if_id_pc_next     <= 32'd0;
        end else if (advance) begin
            if_id_instruction <= imem_rdata;
            if_id_pc_next     <= pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fetch_count <= 32'd0;
        else if (advance)
            fetch_count <= fetch_count + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_next;
    end

    // State is observation only; stall decisions come from hold.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (stall_breakpoint & ~continue_en & ~redirect & ~stall)
                    state_next = BP_WAIT;
            end
            BP_WAIT: begin
                if (continue_en | redirect)
                    state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module : tb_if_stage
// Directed self-checking bench for if_stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        stall_breakpoint;
    logic        continue_en;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc_next;
    logic        flush_id;
    logic        bp_halted;
    logic [31:0] fetch_count;

    int errors = 0;
    int checks = 0;

    if_stage dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .imem_addr         (imem_addr),
        .imem_rdata        (imem_rdata),
        .stall             (stall),
        .stall_breakpoint  (stall_breakpoint),
        .continue_en       (continue_en),
        .redirect          (redirect),
        .redirect_target   (redirect_target),
        .if_id_instruction (if_id_instruction),
        .if_id_pc_next     (if_id_pc_next),
        .flush_id          (flush_id),
        .bp_halted         (bp_halted),
        .fetch_count       (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word at 0 is the reset-vector instruction; elsewhere a tagged address.
    assign imem_rdata = (imem_addr == 32'd0) ? 32'h2008_0005 : (32'hA000_0000 | imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        stall_breakpoint = 1'b0;
        continue_en = 1'b0;
        redirect = 1'b0;
        redirect_target = 32'd0;
        #2;
        check("rst_instr", if_id_instruction, 32'h0);
        check("rst_pcnext", if_id_pc_next, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_halted", {31'd0, bp_halted}, 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_flush", {31'd0, flush_id}, 32'd0);
        step();
        check("rst_hold_addr", imem_addr, 32'h0);
        check("rst_hold_count", fetch_count, 32'd0);
        rst_n = 1'b1;

        step();
        check("fetch0_instr", if_id_instruction, 32'h2008_0005);
        check("fetch0_pcnext", if_id_pc_next, 32'd4);
        check("fetch0_addr", imem_addr, 32'd4);
        check("fetch0_count", fetch_count, 32'd1);
        step();
        check("fetch4_instr", if_id_instruction, 32'hA000_0004);
        check("fetch4_addr", imem_addr, 32'd8);

        // Load-use stall for one edge at pc=8
        stall = 1'b1;
        step();
        check("stall_addr", imem_addr, 32'd8);
        check("stall_instr", if_id_instruction, 32'hA000_0004);
        check("stall_pcnext", if_id_pc_next, 32'd8);
        check("stall_count", fetch_count, 32'd2);
        stall = 1'b0;
        step();
        check("unstall_instr", if_id_instruction, 32'hA000_0008);
        check("unstall_pcnext", if_id_pc_next, 32'd12);
        check("unstall_count", fetch_count, 32'd3);
        step();
        step();
        check("pre_redir_addr", imem_addr, 32'd20);
        check("pre_redir_count", fetch_count, 32'd5);

        // Redirect at pc=20 to 0x40
        redirect = 1'b1;
        redirect_target = 32'h40;
        #1;
        check("flush_comb", {31'd0, flush_id}, 32'd1);
        step();
        redirect = 1'b0;
        #1;
        check("redir_instr", if_id_instruction, 32'h0);
        check("redir_pcnext", if_id_pc_next, 32'h0);
        check("redir_addr", imem_addr, 32'h40);
        check("redir_count", fetch_count, 32'd5);
        check("redir_flush_off", {31'd0, flush_id}, 32'd0);
        step();
        check("target_instr", if_id_instruction, 32'hA000_0040);
        check("target_pcnext", if_id_pc_next, 32'h44);
        check("target_count", fetch_count, 32'd6);

        // Breakpoint hold for 5 cycles
        stall_breakpoint = 1'b1;
        step();
        check("bp_halted1", {31'd0, bp_halted}, 32'd1);
        check("bp_addr1", imem_addr, 32'h44);
        for (int i = 0; i < 4; i++) step();
        check("bp_halted5", {31'd0, bp_halted}, 32'd1);
        check("bp_addr5", imem_addr, 32'h44);
        check("bp_instr5", if_id_instruction, 32'hA000_0040);
        check("bp_count5", fetch_count, 32'd6);
        continue_en = 1'b1;
        step();
        continue_en = 1'b0;
        #1;
        check("cont_halted", {31'd0, bp_halted}, 32'd0);
        check("cont_instr", if_id_instruction, 32'hA000_0044);
        check("cont_addr", imem_addr, 32'h48);
        check("cont_count", fetch_count, 32'd7);
        step();
        check("bp2_halted", {31'd0, bp_halted}, 32'd1);
        check("bp2_addr", imem_addr, 32'h48);

        // Redirect while halted
        redirect = 1'b1;
        redirect_target = 32'h100;
        step();
        redirect = 1'b0;
        stall_breakpoint = 1'b0;
        #1;
        check("bpredir_addr", imem_addr, 32'h100);
        check("bpredir_halted", {31'd0, bp_halted}, 32'd0);
        check("bpredir_instr", if_id_instruction, 32'h0);
        check("bpredir_count", fetch_count, 32'd7);

        // Redirect under stall to wrap-around address
        stall = 1'b1;
        redirect = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        step();
        stall = 1'b0;
        redirect = 1'b0;
        #1;
        check("stallredir_addr", imem_addr, 32'hFFFF_FFFC);
        check("stallredir_halted", {31'd0, bp_halted}, 32'd0);
        step();
        check("wrap_instr", if_id_instruction, 32'hFFFF_FFFC);
        check("wrap_pcnext", if_id_pc_next, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_count", fetch_count, 32'd8);

        // Async reset mid-stall, between edges
        stall = 1'b1;
        step();
        #1;
        rst_n = 1'b0;
        #1;
        check("async_addr", imem_addr, 32'h0);
        check("async_count", fetch_count, 32'd0);
        check("async_instr", if_id_instruction, 32'h0);
        stall = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        check("post_rst_instr", if_id_instruction, 32'h2008_0005);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed=stuck expected=finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
